exec_sequencer: RTL and testbench

Multicycle instruction sequencer for the ARM-subset core: owns the main control FSM, the condition-code register and conditional-execution gating. It generalises the single-cycle flag-source controller to NUM_UNITS execution units (ALU, FPU, multiplier, …), each multi-cycle unit driven by a start/done handshake with a timeout. It skips the execute phase of condition-failed instructions. Combinational field decode (ImmSrc, RegSrc, ALUControl) remains in the decoder; this block drives sequencing strobes only.

---
 rtl/exec_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_exec_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer: main control FSM, NZCV register and conditional-execution
// gating for the ARM-subset core. Multi-cycle execution units are driven by
// a start/done handshake guarded by a wait-cycle timeout.
module exec_sequencer #(
    parameter int NUM_UNITS = 3,
    parameter int SELW      = 2,
    parameter int TMO_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            Instr,
    input  logic [4*NUM_UNITS-1:0] UnitFlags,
    input  logic [NUM_UNITS-1:0]   UnitDone,
    output logic                   PCWrite,
    output logic                   MemWrite,
    output logic                   RegWrite,
    output logic                   IRWrite,
    output logic                   AdrSrc,
    output logic [1:0]             ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             ResultSrc,
    output logic                   UnitStart,
    output logic [SELW-1:0]        UnitSel,
    output logic [3:0]             Flags,
    output logic                   Timeout
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB,
        EXECR, EXECI, ALUWB, BRANCH, UEXEC, UWAIT, UWB
    } state_t;

    // Counter value on the last permitted wait cycle (all-ones after increment).
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    state_t                  state, state_nx;
    logic                    cond_ex, cond_ex_r;
    logic [SELW-1:0]         unit_dec;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [2**SELW-1:0]      done_pad;
    logic [4*(2**SELW)-1:0]  flags_pad;
    logic                    done_sel, tmo_fire;
    logic [1:0]              op;
    logic                    s_bit, rd_pc, is_cmp, cv_upd, flag_op;
    logic                    n_f, z_f, c_f, v_f;
    logic                    unused_ok;

    assign op       = Instr[27:26];
    assign s_bit    = Instr[20];
    assign rd_pc    = (Instr[15:12] == 4'hF);
    assign is_cmp   = (Instr[24:23] == 2'b10);
    assign cv_upd   = (Instr[24:21] == 4'b0100) || (Instr[24:21] == 4'b0010) ||
                      (Instr[24:21] == 4'b1010) || (Instr[24:21] == 4'b1011);
    assign flag_op  = s_bit && (op != 2'b01) && (op != 2'b10);
    assign {n_f, z_f, c_f, v_f} = Flags;
    assign done_sel = done_pad[UnitSel];
    assign tmo_fire = (state == UWAIT) && !done_sel && (tmo_cnt == TMO_LAST);
    assign unused_ok = &{1'b0, Instr[19:16], Instr[11:8], Instr[3:0]};

    // Zero-extend per-unit inputs so UnitSel can index them at full width.
    always_comb begin
        done_pad                     = '0;
        done_pad[NUM_UNITS-1:0]      = UnitDone;
        flags_pad                    = '0;
        flags_pad[4*NUM_UNITS-1:0]   = UnitFlags;
    end

    // Route FP ops and (when present) multiplies to their units, else the ALU.
    always_comb begin
        unit_dec = '0;
        if (op == 2'b11)
            unit_dec = SELW'(1);
        else if (op == 2'b00 && !Instr[25] && Instr[7:4] == 4'b1001 && NUM_UNITS > 2)
            unit_dec = SELW'(2);
    end

    // ARM condition field evaluated against the architectural flags.
    always_comb begin
        cond_ex = 1'b0;
        case (Instr[31:28])
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nx;
    end

    // Next state and per-state strobes; everything held low while in reset.
    always_comb begin
        state_nx  = state;
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        UnitStart = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    IRWrite = 1'b1; PCWrite = 1'b1;
                    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                    state_nx = DECODE;
                end
                DECODE: begin
                    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                    if (!cond_ex)              state_nx = FETCH;
                    else if (op == 2'b01)      state_nx = MEMADR;
                    else if (op == 2'b10)      state_nx = BRANCH;
                    else if (unit_dec != '0)   state_nx = UEXEC;
                    else if (Instr[25])        state_nx = EXECI;
                    else                       state_nx = EXECR;
                end
                MEMADR: begin
                    ALUSrcB  = 2'b01;
                    state_nx = Instr[20] ? MEMRD : MEMWR;
                end
                MEMRD: begin AdrSrc = 1'b1; state_nx = MEMWB; end
                MEMWR: begin AdrSrc = 1'b1; MemWrite = cond_ex_r; state_nx = FETCH; end
                MEMWB: begin RegWrite = cond_ex_r; ResultSrc = 2'b01; state_nx = FETCH; end
                EXECR: state_nx = ALUWB;
                EXECI: begin ALUSrcB = 2'b01; state_nx = ALUWB; end
                ALUWB: begin RegWrite = cond_ex_r && !is_cmp; state_nx = FETCH; end
                BRANCH: begin
                    ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
                    PCWrite = cond_ex_r; state_nx = FETCH;
                end
                UEXEC: begin UnitStart = cond_ex_r; state_nx = UWAIT; end
                UWAIT: begin
                    if (done_sel)      state_nx = UWB;
                    else if (tmo_fire) state_nx = FETCH;
                end
                UWB: begin RegWrite = cond_ex_r; state_nx = FETCH; end
                default: state_nx = FETCH;
            endcase
            // Writing R15 redirects the PC.
            if (RegWrite && rd_pc) PCWrite = 1'b1;
        end
    end

    // Decode-time latches, NZCV updates, wait counter and sticky timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_ex_r <= 1'b0;
            UnitSel   <= '0;
            Flags     <= 4'b0000;
            Timeout   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (state == DECODE) begin
                cond_ex_r <= cond_ex;
                UnitSel   <= unit_dec;
            end
            if ((state == EXECR || state == EXECI) && cond_ex_r && flag_op) begin
                Flags[3:2] <= UnitFlags[3:2];
                if (cv_upd) Flags[1:0] <= UnitFlags[1:0];
            end else if (state == UWAIT && done_sel && cond_ex_r && flag_op) begin
                Flags <= flags_pad[{UnitSel, 2'b00} +: 4];
            end
            if (state == UEXEC)      tmo_cnt <= '0;
            else if (state == UWAIT) tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_fire) Timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: per-cycle expected strobes/flags are
// queued from a reference state walk and popped on each falling edge.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = '0;
    logic [11:0] UnitFlags = '0;
    logic [2:0]  UnitDone = '0;

    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, UnitStart, Timeout;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, UnitSel;
    logic [3:0] Flags;

    logic       d2_pcw, d2_mw, d2_regw, d2_irw, d2_adr, d2_start, d2_tmo;
    logic [1:0] d2_a, d2_b, d2_r, d2_sel;
    logic [3:0] d2_flags;

    logic [11:0] strb_obs;
    assign strb_obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                       ALUSrcA, ALUSrcB, ResultSrc, UnitStart};

    exec_sequencer #(.NUM_UNITS(3), .SELW(2), .TMO_W(4)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .UnitFlags(UnitFlags),
        .UnitDone(UnitDone), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .UnitStart(UnitStart), .UnitSel(UnitSel), .Flags(Flags), .Timeout(Timeout)
    );

    exec_sequencer #(.NUM_UNITS(2), .SELW(2), .TMO_W(4)) dut2 (
        .clk(clk), .reset(reset), .Instr(Instr), .UnitFlags(UnitFlags[7:0]),
        .UnitDone(UnitDone[1:0]), .PCWrite(d2_pcw), .MemWrite(d2_mw),
        .RegWrite(d2_regw), .IRWrite(d2_irw), .AdrSrc(d2_adr),
        .ALUSrcA(d2_a), .ALUSrcB(d2_b), .ResultSrc(d2_r),
        .UnitStart(d2_start), .UnitSel(d2_sel), .Flags(d2_flags), .Timeout(d2_tmo)
    );

    always #5 clk = ~clk;

    typedef enum int {S_F, S_D, S_MA, S_MR, S_MW, S_MWB, S_ER, S_EI,
                      S_AW, S_BR, S_UE, S_UW, S_UWB} st_t;

    typedef struct packed {
        logic [11:0] strb;
        logic [3:0]  flags;
        logic        tmo;
        logic [1:0]  usel;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] m_flags = 4'b0000;
    logic       m_tmo = 1'b0;
    logic [1:0] m_usel = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;           4'h1: return !z;
            4'h2: return c;           4'h3: return !c;
            4'h4: return n;           4'h5: return !n;
            4'h6: return v;           4'h7: return !v;
            4'h8: return c && !z;     4'h9: return !c || z;
            4'hA: return n == v;      4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int unit_of(input logic [31:0] i);
        if (i[27:26] == 2'b11) return 1;
        if (i[27:26] == 2'b00 && !i[25] && i[7:4] == 4'b1001) return 2;
        return 0;
    endfunction

    // Strobe table: {PCW, MemW, RegW, IRW, AdrSrc, SrcA, SrcB, ResSrc, UnitStart}
    function automatic logic [11:0] strb_of(input st_t s, input logic [31:0] i);
        logic pcw, mw, rw, irw, adr, us;
        logic [1:0] a, b, r;
        {pcw, mw, rw, irw, adr, us} = '0;
        a = 2'b00; b = 2'b00; r = 2'b00;
        case (s)
            S_F:   begin pcw = 1; irw = 1; a = 2'b01; b = 2'b10; r = 2'b10; end
            S_D:   begin a = 2'b01; b = 2'b10; r = 2'b10; end
            S_MA:  b = 2'b01;
            S_MR:  adr = 1;
            S_MW:  begin adr = 1; mw = 1; end
            S_MWB: begin rw = 1; r = 2'b01; end
            S_EI:  b = 2'b01;
            S_AW:  rw = (i[24:23] != 2'b10);
            S_BR:  begin a = 2'b10; b = 2'b01; r = 2'b10; pcw = 1; end
            S_UE:  us = 1;
            S_UWB: rw = 1;
            default: ;
        endcase
        if (rw && i[15:12] == 4'hF) pcw = 1;
        return {pcw, mw, rw, irw, adr, a, b, r, us};
    endfunction

    // Called at posedge+1 of the instruction's FETCH cycle; returns at the next FETCH.
    task automatic run(input logic [31:0] instr, input logic [11:0] uflags,
                       input int done_l, input int stray_c, input logic [2:0] stray_m);
        st_t  seq[$];
        exp_t e;
        int   u, wait_n;
        logic ok;
        Instr = instr;
        UnitFlags = uflags;
        u = unit_of(instr);
        ok = (done_l >= 1 && done_l <= 15);
        seq = {S_F, S_D};
        if (cond_ok(instr[31:28], m_flags)) begin
            if (instr[27:26] == 2'b01) begin
                seq.push_back(S_MA);
                if (instr[20]) begin seq.push_back(S_MR); seq.push_back(S_MWB); end
                else seq.push_back(S_MW);
            end else if (instr[27:26] == 2'b10) begin
                seq.push_back(S_BR);
            end else if (u != 0) begin
                seq.push_back(S_UE);
                wait_n = ok ? done_l : 15;
                repeat (wait_n) seq.push_back(S_UW);
                if (ok) seq.push_back(S_UWB);
            end else begin
                seq.push_back(instr[25] ? S_EI : S_ER);
                seq.push_back(S_AW);
            end
        end
        for (int k = 0; k < seq.size(); k++) begin
            e.strb = strb_of(seq[k], instr);
            e.flags = m_flags;
            e.tmo = m_tmo;
            e.usel = m_usel;
            sb_q.push_back(e);
            case (seq[k])
                S_D: m_usel = 2'(u);
                S_ER, S_EI: if (instr[20]) begin
                    m_flags[3:2] = uflags[3:2];
                    if (instr[24:21] inside {4'b0100, 4'b0010, 4'b1010, 4'b1011})
                        m_flags[1:0] = uflags[1:0];
                end
                S_UW: begin
                    if (k + 1 < seq.size() && seq[k+1] == S_UWB) begin
                        if (instr[20]) m_flags = uflags[4*u +: 4];
                    end else if (k + 1 == seq.size()) m_tmo = 1'b1;
                end
                default: ;
            endcase
        end
        for (int c = 1; c <= seq.size(); c++) begin
            UnitDone = '0;
            if (c == stray_c) UnitDone = stray_m;
            if (u != 0 && done_l > 0 && c == 3 + done_l) UnitDone[u] = 1'b1;
            @(posedge clk); #1;
        end
        UnitDone = '0;
    endtask

    // Pop one expectation per cycle while instructions are in flight.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("strobes", 32'(strb_obs), 32'(e.strb));
            check("flags", 32'(Flags), 32'(e.flags));
            check("timeout", 32'(Timeout), 32'(e.tmo));
            check("unitsel", 32'(UnitSel), 32'(e.usel));
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", 32'(strb_obs), 0);
        check("rst_flags", 32'(Flags), 0);
        check("rst_timeout", 32'(Timeout), 0);
        check("rst_unitsel", 32'(UnitSel), 0);
        reset = 1'b0;

        run(32'hE0821003, 12'h000, 0, 0, 3'b000); // ADD r1,r2,r3
        run(32'hE0511001, 12'h006, 0, 0, 3'b000); // SUBS -> Z,C
        run(32'h0A000002, 12'h000, 0, 0, 3'b000); // BEQ taken
        run(32'h1A000002, 12'h000, 0, 0, 3'b000); // BNE skipped
        run(32'hE0912003, 12'h00B, 0, 0, 3'b000); // ADDS: NZCV all update
        run(32'hE0112003, 12'h004, 0, 0, 3'b000); // ANDS: NZ only
        run(32'hE1510002, 12'h009, 0, 0, 3'b000); // CMP: no RegWrite
        run(32'hCA000001, 12'h000, 0, 0, 3'b000); // BGT taken (N==V, !Z)
        run(32'hE2811001, 12'h000, 0, 0, 3'b000); // ADD immediate
        run(32'hE1A0F00E, 12'h000, 0, 0, 3'b000); // MOV pc,lr
        run(32'hE5912000, 12'h000, 0, 0, 3'b000); // LDR
        run(32'hE5812000, 12'h000, 0, 0, 3'b000); // STR
        run(32'hEE110200, 12'h085, 5, 0, 3'b000); // FP op, done after 5 waits
        run(32'hEE110200, 12'h035, 15, 0, 3'b000); // done on saturation cycle

        fork
            run(32'hE0010392, 12'h0F0, 2, 4, 3'b010); // MUL, stray unit-1 done
            begin
                for (int c = 1; c <= 4; c++) begin
                    @(negedge clk);
                    check("u2_start", 32'(d2_start), 0);
                    if (c == 3) check("u2_sel", 32'(d2_sel), 0);
                    if (c == 4) check("u2_regwrite", 32'(d2_regw), 1);
                end
            end
        join

        run(32'hEE110200, 12'h0F0, 0, 0, 3'b000); // unit never answers
        run(32'hE0821003, 12'h000, 0, 1, 3'b111); // stray done in FETCH
        run(32'hEE110200, 12'h060, 4, 3, 3'b010); // stray done in UEXEC

        // Reset while waiting on a unit.
        Instr = 32'hEE110200;
        UnitFlags = 12'h0A0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_strobes", 32'(strb_obs), 0);
        check("midrst_flags", 32'(Flags), 0);
        check("midrst_timeout", 32'(Timeout), 0);
        check("midrst_unitsel", 32'(UnitSel), 0);
        m_flags = 4'b0000;
        m_tmo = 1'b0;
        m_usel = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(32'hE0821003, 12'h000, 0, 0, 3'b000);

        check("sb_drain", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
